// File: rtl/qam16_burst_ctrl_pkg.sv
// Shared types and constants for the 16-QAM burst sequencer.
package qam16_pkg;
  localparam int QAM_BITS = 4;

  typedef enum logic [1:0] {IDLE, PRE, PAY, FLUSH} state_e;

  localparam logic [QAM_BITS-1:0] PRE_A_DEF = 4'b0000;
  localparam logic [QAM_BITS-1:0] PRE_B_DEF = 4'b1111;
endpackage

// File: rtl/qam16_sym_tick.sv
// Modulo-SPS tick counter; flags the symbol-slot cycle (tick 0) and the last tick of a symbol period.
module qam16_sym_tick
  import qam16_pkg::*;
#(
  parameter int SPS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic slot,
  output logic last_tick
);
  localparam int TW = (SPS > 1) ? $clog2(SPS) : 1;

  logic [TW-1:0] tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
    end else if (clr) begin
      tick_q <= '0;
    end else if (en) begin
      tick_q <= (tick_q == TW'(SPS - 1)) ? '0 : tick_q + 1'b1;
    end
  end

  assign slot      = en && (tick_q == '0);
  assign last_tick = (tick_q == TW'(SPS - 1));
endmodule

// File: rtl/qam16_burst_ctrl.sv
// 16-QAM burst sequencer: preamble, paced payload pull, zero flush to drain the FIRs,
// plus a lockstep monitor on the I/Q FIR output-valid pair.
module qam16_burst_ctrl
  import qam16_pkg::*;
#(
  parameter int                  SPS        = 4,
  parameter int                  N_PRE      = 4,
  parameter logic [QAM_BITS-1:0] PRE_A      = PRE_A_DEF,
  parameter logic [QAM_BITS-1:0] PRE_B      = PRE_B_DEF,
  parameter int                  FLUSH_SYMS = 8,
  parameter int                  LEN_W      = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    burst_len,
  input  logic [QAM_BITS-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [QAM_BITS-1:0] sym_bits,
  output logic                sym_valid,
  output logic                sym_zero,
  output logic                fir_en,
  input  logic                firo_valid_i,
  input  logic                firo_valid_q,
  output logic                busy,
  output logic                done,
  output logic                underrun,
  output logic                iq_mismatch
);
  localparam int FW    = $clog2(FLUSH_SYMS + 1);
  localparam int PW    = $clog2(N_PRE + 1);
  localparam int FPW   = (FW > PW) ? FW : PW;
  localparam int CNT_W = (LEN_W > FPW) ? LEN_W : FPW;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q;
  logic             done_d;
  logic             accept;
  logic             slot;
  logic             last_tick;
  logic             pay_slot;

  assign busy      = (state_q != IDLE);
  assign fir_en    = busy;
  // The done cycle is still IDLE, so start must be masked explicitly there.
  assign accept    = (state_q == IDLE) && start && !done;
  assign pay_slot  = (state_q == PAY) && slot;
  assign din_ready = pay_slot;

  qam16_sym_tick #(.SPS(SPS)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .en        (busy),
    .slot      (slot),
    .last_tick (last_tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        if (slot) begin
          if (cnt_q == CNT_W'(N_PRE - 1)) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? FLUSH : PAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAY: begin
        if (slot) begin
          if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // After the last flush slot, finish out its symbol period before going idle.
        if (slot) begin
          cnt_d = cnt_q + 1'b1;
        end else if ((cnt_q == CNT_W'(FLUSH_SYMS)) && last_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) len_q <= burst_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_valid <= 1'b0;
      sym_bits  <= '0;
      sym_zero  <= 1'b0;
    end else begin
      sym_valid <= slot;
      if (slot) begin
        unique case (state_q)
          PRE: begin
            sym_bits <= cnt_q[0] ? PRE_B : PRE_A;
            sym_zero <= 1'b0;
          end
          PAY: begin
            sym_bits <= din_valid ? din : '0;
            sym_zero <= !din_valid;
          end
          default: begin
            sym_bits <= '0;
            sym_zero <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun    <= 1'b0;
      iq_mismatch <= 1'b0;
    end else if (accept) begin
      underrun    <= 1'b0;
      iq_mismatch <= 1'b0;
    end else begin
      if (pay_slot && !din_valid) underrun <= 1'b1;
      if (busy && (firo_valid_i != firo_valid_q)) iq_mismatch <= 1'b1;
    end
  end
endmodule

// File: doc/qam16_burst_ctrl.md
Name: qam16_burst_ctrl

Overview:
- Burst sequencer for the 16-QAM transmit path.
- On a start request it schedules one burst onto the mapper and the I/Q pulse-shaping FIRs, in this order:
  - fixed preamble symbols;
  - payload nibbles pulled from the upstream bit source via valid/ready;
  - zero-amplitude flush symbols, so both FIRs drain.
- Paces symbols at one per SPS clocks and monitors the FIR I/Q output-valid pair for lockstep errors.
- Sits between the bit source and the mapper/FIR stage, in front of the combined I/Q output.

Parameters:
- SPS, 4, clocks per symbol (upsampling factor); must be >= 2.
- N_PRE, 4, number of preamble symbols; must be >= 1.
- PRE_A, 4'b0000, preamble nibble on even preamble symbols.
- PRE_B, 4'b1111, preamble nibble on odd preamble symbols.
- FLUSH_SYMS, 8, number of zero symbols after the payload; must be >= ceil(FIR taps / SPS).
- LEN_W, 12, width of the burst length field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- burst_len  in  LEN_W  payload symbol count; latched when start is accepted.
- din  in  4  payload nibble from the bit source.
- din_valid  in  1  din is valid.
- din_ready  out  1  controller takes din this cycle.
- sym_bits  out  4  nibble to the 16-QAM mapper.
- sym_valid  out  1  one-cycle strobe per symbol slot.
- sym_zero  out  1  with sym_valid: mapper outputs 0+0j instead of sym_bits.
- fir_en  out  1  FIR enable; high while busy.
- firo_valid_i  in  1  I-branch FIR output valid.
- firo_valid_q  in  1  Q-branch FIR output valid.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- underrun  out  1  sticky: a payload slot found din_valid low.
- iq_mismatch  out  1  sticky: firo_valid_i != firo_valid_q in some cycle while busy.

Behaviour:
- Reset (asynchronous, any time including mid-burst):
  - state = IDLE; tick and symbol counters = 0.
  - All outputs = 0.
  - No partial burst resumes.
- States and transitions:
  - IDLE -> PRE on start; start while busy is ignored.
  - PRE -> PAY after N_PRE slots, or PRE -> FLUSH if the latched len = 0.
  - PAY -> FLUSH after len slots.
  - FLUSH -> IDLE after FLUSH_SYMS slots.
- Start acceptance at edge k:
  - Latch burst_len.
  - Clear underrun and iq_mismatch.
  - Tick counter = 0.
  - busy and fir_en go high after edge k.
- Symbol slots: slot n (n = 0 .. N_PRE+len+FLUSH_SYMS-1) occurs at edge k+1+n*SPS. The tick counter wraps SPS-1 -> 0 and a slot fires when tick = 0.
- Registered outputs: sym_valid, sym_bits and sym_zero update at the slot edge. sym_valid is high for exactly one cycle after the slot edge and 0 otherwise. sym_bits holds its value between slots.
- PRE slots: sym_bits = PRE_A for even index, PRE_B for odd index; sym_zero = 0.
- PAY handshake:
  - din_ready = 1 combinationally only in the cycle before a PAY slot edge (state PAY and tick = 0).
  - Transfer occurs when din_valid & din_ready; din appears on sym_bits after that edge (latency 1).
  - If din_valid = 0 at the slot: emit sym_zero = 1, set underrun, and still count the slot. Burst length and timing are never stretched.
- FLUSH slots: sym_zero = 1, sym_bits = 0.
- Burst end:
  - The last FLUSH slot is at edge E = k+1+(total_slots-1)*SPS.
  - At edge E+SPS-1: state -> IDLE, busy = 0, fir_en = 0, done = 1 for one cycle.
  - Total busy length = total_slots*SPS cycles.
  - start coincident with done is ignored; start one cycle later is accepted.
- len counter: compares against the latched length, so burst_len changes mid-burst have no effect. Full-scale len = 2^LEN_W-1 is legal.
- iq_mismatch is evaluated only while busy; it holds until the next accepted start or reset.

Decomposition:
- Package qam16_pkg: state enum (IDLE, PRE, PAY, FLUSH); QAM_BITS = 4; default PRE_A and PRE_B constants.
- One sub-module, qam16_sym_tick: a modulo-SPS counter with clear and enable that outputs a slot pulse.
- The FSM and the symbol/length counters stay in the top level.

Test Plan:
- Length-3 burst, din always valid (SPS=4, N_PRE=4, FLUSH_SYMS=8, start at edge k, payload 4'h3, 4'hA, 4'h5):
  - sym_valid at 15 slots spaced 4 cycles, first after edge k+1.
  - sym_bits sequence 0, F, 0, F, 3, A, 5, then 8 slots with sym_zero = 1.
  - busy high for 60 cycles; done after edge k+60.
- len = 0 burst: 4 preamble slots then 8 flush slots; din_ready never asserted; done after 48 busy cycles.
- din_valid dropped for payload slot 1 of 3:
  - that slot has sym_zero = 1 and underrun = 1.
  - done is still at the same cycle as the no-underrun case.
  - underrun clears on the next accepted start.
- firo_valid_i held 1 while firo_valid_q = 0 for one cycle mid-burst: iq_mismatch = 1 and stays set through done.
- Start pulses:
  - start asserted while busy: no effect.
  - start in the done cycle: ignored.
  - start the cycle after done: a new burst begins.
- Reset asserted mid-PAY: all outputs 0 immediately (asynchronously), then IDLE; a subsequent start runs a clean full burst.
